// File: rtl/sync2a1_word.sv
// -----------------------------------------------------------------------------
// sync2a1_word
//
// Carries a DW-bit word plus its strobe from the slow clk2 domain into the fast
// clk1 domain using a toggle request / toggle acknowledge handshake. The source
// side captures the word into a holding register that stays static while the
// handshake is open. The destination therefore samples a stable bus and only
// the single-bit req/ack toggles pass through synchronizer flops.
//
// Optional feature (macro SYNC2A1_OVF_EN):
//   defined   - ovf is a sticky flag. It sets when x arrives while the source is
//               busy, and ovf_clr clears it. A set and a clear on the same
//               clk2 edge leave ovf set.
//   undefined - ovf is tied low and ovf_clr is ignored. Dropped strobes are
//               silent.
//
// Parameters:
//   DW      data word width (1..64)
//   STAGES  synchronizer flops per crossing (2..4)
//
// Ports:
//   clk1     in   destination (fast) clock
//   rstb     in   asynchronous active-low reset, released per domain through
//                 a 2-flop reset synchronizer
//   clk2     in   source (slow) clock
//   x        in   clk2 domain, load strobe
//   din      in   clk2 domain, word taken on a clk2 edge with x=1 and rdy=1
//   rdy      out  clk2 domain, 1 = source idle and the next x is accepted
//   ovf_clr  in   clk2 domain, clears ovf
//   ovf      out  clk2 domain, sticky drop flag
//   y        out  clk1 domain, valid pulse one clk1 cycle wide
//   dout     out  clk1 domain, last transferred word, held between transfers
// -----------------------------------------------------------------------------
module sync2a1_word #(
  parameter int DW     = 16,
  parameter int STAGES = 2
) (
  input  logic          clk1,
  input  logic          rstb,
  input  logic          clk2,
  input  logic          x,
  input  logic [DW-1:0] din,
  output logic          rdy,
  input  logic          ovf_clr,
  output logic          ovf,
  output logic          y,
  output logic [DW-1:0] dout
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } src_state_t;

  // ---------------------------------------------------------------------------
  // Per-domain reset synchronizers. Assertion is immediate, and release is
  // aligned to the local clock so that no flop sees reset removal near its edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst1_sync;
  logic [1:0] rst2_sync;
  logic       rst1_n;
  logic       rst2_n;

  // NOTE: every clocked block assigns state with <= so that all flops sample
  // the pre-edge values; a blocking = here would make one flop see another's
  // new value in the same edge and collapse the synchronizer chain.
  always_ff @(posedge clk1 or negedge rstb) begin
    if (!rstb) rst1_sync <= 2'b00;
    else       rst1_sync <= {rst1_sync[0], 1'b1};
  end

  always_ff @(posedge clk2 or negedge rstb) begin
    if (!rstb) rst2_sync <= 2'b00;
    else       rst2_sync <= {rst2_sync[0], 1'b1};
  end

  assign rst1_n = rst1_sync[1];
  assign rst2_n = rst2_sync[1];

  // ---------------------------------------------------------------------------
  // Handshake signals shared by both sides.
  //   req  : clk2 flop, toggles once per accepted word
  //   ack  : clk1 flop, follows req after the word has been loaded
  //   hold : clk2 flop, static whenever req != ack
  // ---------------------------------------------------------------------------
  logic          req;
  logic          ack;
  logic [DW-1:0] hold;

  // ---------------------------------------------------------------------------
  // Source side (clk2)
  // ---------------------------------------------------------------------------
  src_state_t        state;
  logic [STAGES-1:0] ack_sync;
  logic              ack_s;

  assign ack_s = ack_sync[STAGES-1];

  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n) ack_sync <= '0;
    else         ack_sync <= {ack_sync[STAGES-2:0], ack};
  end

  // rdy is a registered copy of (state == S_IDLE), so the clk2-domain
  // consumer gets a glitch-free output.
  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n) begin
      state <= S_IDLE;
      rdy   <= 1'b1;
      req   <= 1'b0;
      // NOTE: hold is a plain register, not a memory array, and it has a
      // defined reset value. Resetting it costs nothing and keeps the value
      // that could reach dout deterministic.
      hold  <= '0;
    end else begin
      // NOTE: in always_ff a branch that leaves a signal unassigned simply
      // keeps the flop's value. Only an incomplete always_comb would infer a
      // latch.
      case (state)
        S_IDLE: begin
          if (x) begin
            hold  <= din;
            req   <= ~req;
            rdy   <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The round trip is complete once the synchronized ack has caught
          // up with req. Strobes seen meanwhile are dropped.
          if (ack_s == req) begin
            rdy   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Destination side (clk1)
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] req_sync;
  logic              req_d;
  logic              req_q;
  logic              req_edge;

  assign req_d    = req_sync[STAGES-1];
  assign req_edge = (req_d != req_q);

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      req_sync <= '0;
      req_q    <= 1'b0;
      y        <= 1'b0;
      dout     <= '0;
      ack      <= 1'b0;
    end else begin
      req_sync <= {req_sync[STAGES-2:0], req};
      req_q    <= req_d;
      y        <= req_edge;
      // hold has been static for at least STAGES clk1 cycles here. It cannot
      // change until the ack toggled below has crossed back, so a plain
      // multi-bit capture is safe.
      if (req_edge) begin
        dout <= hold;
        ack  <= req_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drop flag
  // ---------------------------------------------------------------------------
`ifdef SYNC2A1_OVF_EN
  always_ff @(posedge clk2 or negedge rst2_n) begin
    if (!rst2_n)          ovf <= 1'b0;
    else if (x && !rdy)   ovf <= 1'b1;   // set has priority over clear
    else if (ovf_clr)     ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: doc/sync2a1_word.md
# sync2a1_word

Clock-domain crossing that carries a DW-bit data word plus its strobe from the slow domain (clk2) into the fast domain (clk1), complementing the existing clk1→clk2 pulse synchronizer used in the ADC unit. A source-side state machine captures the word into a stable holding register and signals it with a toggle request. The destination side detects the toggle, loads the word and returns a toggle acknowledge. The block sits between slow-clock configuration/trigger logic and the fast ADC sampling datapath.

## Interface
Parameters:
- DW, 16, data word width (1..64)
- STAGES, 2, synchronizer flops per crossing (2..4)

Ports:
- clk1  in  1  destination (fast) clock
- rstb  in  1  reset; asynchronous, active-low, clock clk1
- clk2  in  1  source (slow) clock
- x  in  1  clk2 domain, load strobe
- din  in  DW  clk2 domain, word sampled on clk2 edge with x=1 and rdy=1
- rdy  out  1  clk2 domain, 1 = source idle, next x accepted
- ovf_clr  in  1  clk2 domain, clears ovf
- ovf  out  1  clk2 domain, sticky drop flag (see Configuration)
- y  out  1  clk1 domain, one-clk1-cycle valid pulse
- dout  out  DW  clk1 domain, last transferred word, held between transfers

## Operation
- Reset: rstb asserts asynchronously in both domains; deassertion passes through a 2-flop reset synchronizer per domain. Reset values: rdy=1 (after clk2 reset release), y=0, dout=0, ovf=0, req=ack=0, hold=0, FSM=S_IDLE.
- Source FSM (clk2):
  - S_IDLE: rdy=1. On x=1: hold<=din, req<=~req, go S_WAIT.
  - S_WAIT: rdy=0. x ignored (dropped). When ack_s (ack through STAGES clk2 flops) == req, go S_IDLE.
- Destination (clk1): req_d = req through STAGES clk1 flops; req_q = req_d delayed one cycle. When req_d != req_q: dout<=hold, y<=1 for one cycle, ack<=req_d.
- hold is static whenever req and ack differ, so dout captures a stable bus; no per-bit synchronization of data.
- Each accepted x produces exactly one y; never duplicated, never lost.
- Reset mid-transfer: both sides return to reset values, pending word discarded, no y after release.

## Timing
- Forward latency: y high STAGES+1 to STAGES+2 clk1 edges after the clk2 edge accepting x; dout valid in the same cycle as y, stable until the next y.
- Return: rdy reasserts STAGES+1 to STAGES+2 clk2 edges after ack toggles.
- Peak throughput: one word per (STAGES+2) clk1 + (STAGES+2) clk2 cycles.
- Clocks fully asynchronous; no frequency ratio required for correctness.
- x held high continuously: a new word is taken on each S_IDLE cycle, i.e. back-to-back at peak throughput.

## Configuration
- Macro SYNC2A1_OVF_EN.
- Defined: ovf sets on any clk2 edge with x=1 and rdy=0; stays 1 until ovf_clr=1 or reset; if set and clear coincide, set wins.
- Undefined: ovf tied 0, ovf_clr ignored; drops are silent. Port list unchanged either way.

## Test plan
- Reset: assert rstb mid-run -> y=0, dout=0, rdy=1, ovf=0 after release; no spurious y.
- Single word: clk1=100 MHz, clk2=10 MHz, STAGES=2, x pulse with din=16'hA5C3 -> exactly one y within 4 clk1 edges, dout=16'hA5C3, rdy back to 1 within 4 clk2 edges of ack.
- Burst: x held high, din incrementing 0..99 -> y count equals accepted-word count, dout sequence strictly follows accepted din values, no repeats.
- Drop (SYNC2A1_OVF_EN defined): x during S_WAIT with din=16'hFFFF -> word not delivered, ovf=1; ovf_clr pulse -> ovf=0; set+clear in the same cycle -> ovf=1.
- Drop without macro: same stimulus -> word not delivered, ovf stays 0.
- Clock sweep: randomized clk1/clk2 phases, ratios 1:1 to 20:1, 1000 words -> all delivered in order, dout never changes without y.
